// File: rtl/led_catcher_param.sv
// Parametrised LED catcher game: a single lit LED sweeps back and forth, and a
// rising edge on the switch under it scores a catch and freezes the LED.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   switch  : raw slide switches, asynchronous to clk
//   state   : one-hot LED drive, bit N_LEDS-1 is the leftmost LED
//   score   : saturating binary score, feeds the BCD display path
//   frozen  : high while the post-catch freeze is active
//   catch_p : one-cycle pulse on a scoring catch
//   miss_p  : one-cycle pulse on a penalised miss (only when MISS_PENALTY=1)
module led_catcher_param #(
    parameter int unsigned N_LEDS       = 16,
    parameter int unsigned STEP_DIV     = 10_000_000,
    parameter int unsigned FREEZE_STEPS = 30,
    parameter int unsigned SCORE_W      = 10,
    parameter bit          MISS_PENALTY = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LEDS-1:0]  switch,
    output logic [N_LEDS-1:0]  state,
    output logic [SCORE_W-1:0] score,
    output logic               frozen,
    output logic               catch_p,
    output logic               miss_p
);

    localparam int unsigned POS_W = $clog2(N_LEDS);
    localparam int unsigned CNT_W = $clog2(STEP_DIV);
    localparam int unsigned FRZ_W = $clog2(FREEZE_STEPS + 1);

    localparam logic [POS_W-1:0]   POS_MAX   = POS_W'(N_LEDS - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(STEP_DIV - 1);
    localparam logic [FRZ_W-1:0]   FRZ_LOAD  = FRZ_W'(FREEZE_STEPS);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [N_LEDS-1:0]  STATE_RST = N_LEDS'(1) << (N_LEDS - 1);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_FROZEN = 1'b1
    } fsm_t;

    logic [N_LEDS-1:0]  sw_meta;
    logic [N_LEDS-1:0]  sw_s;
    logic [N_LEDS-1:0]  sw_d;
    logic [N_LEDS-1:0]  sw_rise;
    logic [CNT_W-1:0]   step_cnt;
    logic               tick_c;

    fsm_t               fsm_q,     fsm_d;
    logic [POS_W-1:0]   pos_q,     pos_d;
    logic               dir_up_q,  dir_up_d;
    logic [FRZ_W-1:0]   frz_cnt_q, frz_cnt_d;
    logic [SCORE_W-1:0] score_d;
    logic               catch_d;
    logic               miss_d;

    // Synchroniser, delay stage and registered rising-edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_meta <= '0;
            sw_s    <= '0;
            sw_d    <= '0;
            sw_rise <= '0;
        end else begin
            sw_meta <= switch;
            sw_s    <= sw_meta;
            sw_d    <= sw_s;
            sw_rise <= sw_s & ~sw_d;
        end
    end

    // Free-running step divider; a catch never restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (tick_c) begin
            step_cnt <= '0;
        end else begin
            step_cnt <= step_cnt + CNT_W'(1);
        end
    end

    assign tick_c = (step_cnt == CNT_MAX);

    // Game state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q     <= ST_RUN;
            pos_q     <= POS_MAX;
            dir_up_q  <= 1'b0;
            frz_cnt_q <= '0;
            state     <= STATE_RST;
            score     <= '0;
            frozen    <= 1'b0;
            catch_p   <= 1'b0;
            miss_p    <= 1'b0;
        end else begin
            fsm_q     <= fsm_d;
            pos_q     <= pos_d;
            dir_up_q  <= dir_up_d;
            frz_cnt_q <= frz_cnt_d;
            state     <= N_LEDS'(1) << pos_d;
            score     <= score_d;
            frozen    <= (fsm_d == ST_FROZEN);
            catch_p   <= catch_d;
            miss_p    <= miss_d;
        end
    end

    // Next-state: catch beats tick; while frozen only the freeze countdown runs
    always_comb begin
        fsm_d     = fsm_q;
        pos_d     = pos_q;
        dir_up_d  = dir_up_q;
        frz_cnt_d = frz_cnt_q;
        score_d   = score;
        catch_d   = 1'b0;
        miss_d    = 1'b0;

        case (fsm_q)
            ST_RUN: begin
                if (sw_rise[pos_q]) begin
                    catch_d   = 1'b1;
                    fsm_d     = ST_FROZEN;
                    frz_cnt_d = FRZ_LOAD;
                    if (score != SCORE_MAX) begin
                        score_d = score + SCORE_W'(1);
                    end
                end else begin
                    // Several unlit edges in one cycle collapse into one miss
                    if (MISS_PENALTY && (|sw_rise)) begin
                        miss_d = 1'b1;
                        if (score != '0) begin
                            score_d = score - SCORE_W'(1);
                        end
                    end
                    // Direction flips on arrival at an endpoint so each end is shown once
                    if (tick_c) begin
                        if (dir_up_q) begin
                            pos_d = pos_q + POS_W'(1);
                            if (pos_q == POS_MAX - POS_W'(1)) begin
                                dir_up_d = 1'b0;
                            end
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                            if (pos_q == POS_W'(1)) begin
                                dir_up_d = 1'b1;
                            end
                        end
                    end
                end
            end
            ST_FROZEN: begin
                // The tick that empties the counter only unfreezes; movement waits a tick
                if (tick_c) begin
                    frz_cnt_d = frz_cnt_q - FRZ_W'(1);
                    if (frz_cnt_q == FRZ_W'(1)) begin
                        fsm_d = ST_RUN;
                    end
                end
            end
            default: begin
                fsm_d = ST_RUN;
            end
        endcase
    end

endmodule
